// File: rtl/dac_spi_sequencer.sv
// dac_spi_sequencer: buffers one audio sample and shifts it out as a 16-bit SPI DAC command frame, then strobes LDAC
module dac_spi_sequencer #(
  parameter int   clock_max   = 25_000_000,
  parameter int   clk_div     = 4,
  parameter logic signed_in   = 1'b1,
  parameter logic dac_channel = 1'b0,
  parameter logic buffered    = 1'b0,
  parameter logic gain_n      = 1'b1
) (
  input  logic        audio_clock,
  input  logic        reset,
  input  logic        enable_in,
  input  logic        sample_valid,
  input  logic [15:0] sample_in,
  output logic        sample_ready,
  output logic        sclk_out,
  output logic        mosi_out,
  output logic        cs_n_out,
  output logic        ldac_n_out,
  output logic        busy_out,
  output logic        frame_done_out
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, CSHI = 2'd2, LDAC = 2'd3;
  localparam logic [7:0] div_last = 8'(clk_div - 1);
  if (clk_div < 1 || clk_div > 255 || clock_max < 2 * clk_div) begin : g_bad_div
    $error("dac_spi_sequencer: clk_div must be 1..255 and SCLK no faster than audio_clock/2");
  end
  logic [1:0] state;
  logic [7:0] div_cnt;
  logic [3:0] bit_cnt;
  logic [15:0] shreg;
  logic [11:0] hold;
  logic full, full_next, take, load, phase_end, unused_lsbs;
  logic [15:0] word;
  // the 4 LSBs are truncated away; the sample is converted to 12-bit offset binary on capture
  assign unused_lsbs = ^sample_in[3:0];
  assign take = sample_valid && sample_ready;
  assign load = state == IDLE && full && enable_in;
  assign full_next = take || (full && !load);
  assign phase_end = div_cnt == div_last;
  assign word = {dac_channel, buffered, gain_n, 1'b1, hold};
  always_ff @(posedge audio_clock) begin
    if (reset) begin
      state <= IDLE;
      full <= 1'b0;
      hold <= '0;
      sample_ready <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      sclk_out <= 1'b0;
      mosi_out <= 1'b0;
      cs_n_out <= 1'b1;
      ldac_n_out <= 1'b1;
      busy_out <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      if (take) hold <= signed_in ? {~sample_in[15], sample_in[14:4]} : sample_in[15:4];
      full <= full_next;
      sample_ready <= !full_next;
      frame_done_out <= 1'b0;
      div_cnt <= (state == IDLE || phase_end) ? '0 : div_cnt + 8'd1;
      case (state)
        IDLE: if (load) begin
          state <= SHIFT;
          shreg <= {word[14:0], 1'b0};
          mosi_out <= word[15];
          cs_n_out <= 1'b0;
          bit_cnt <= 4'd15;
          busy_out <= 1'b1;
        end
        SHIFT: if (phase_end) begin
          if (!sclk_out) sclk_out <= 1'b1;
          else if (bit_cnt == 4'd0) begin
            state <= CSHI;
            sclk_out <= 1'b0;
            mosi_out <= 1'b0;
            cs_n_out <= 1'b1;
          end else begin
            sclk_out <= 1'b0;
            mosi_out <= shreg[15];
            shreg <= {shreg[14:0], 1'b0};
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        CSHI: if (phase_end) begin
          state <= LDAC;
          ldac_n_out <= 1'b0;
        end
        default: if (phase_end) begin
          state <= IDLE;
          ldac_n_out <= 1'b1;
          busy_out <= 1'b0;
          frame_done_out <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_sequencer.sv
// tb_dac_spi_sequencer: directed and random checks of three sequencer variants against a frame-level model
module tb_dac_spi_sequencer;
  logic audio_clock = 1'b0;
  logic reset, enable_in, sample_valid;
  logic [15:0] sample_in;
  logic [2:0] ready, sclk, mosi, cs_n, ldac_n, busy, done;
  int tests = 0, fails = 0, cyc = 0;
  int lc[3], run[3], nb[3], sf[3], lac[3], fr[3];
  logic [15:0] wd[3], lw[3];
  logic pc[3], ps[3], pl[3], pm[3];
  bit act[3], tmg[3], wl[3], hs[3];
  logic [15:0] q[3][$];
  int ft[$];

  always #5 audio_clock = ~audio_clock;

  // instance 0: defaults, 1: clk_div=1, 2: unsigned input
  dac_spi_sequencer d4 (.audio_clock(audio_clock), .reset(reset), .enable_in(enable_in), .sample_valid(sample_valid),
    .sample_in(sample_in), .sample_ready(ready[0]), .sclk_out(sclk[0]), .mosi_out(mosi[0]), .cs_n_out(cs_n[0]),
    .ldac_n_out(ldac_n[0]), .busy_out(busy[0]), .frame_done_out(done[0]));
  dac_spi_sequencer #(.clk_div(1)) d1 (.audio_clock(audio_clock), .reset(reset), .enable_in(enable_in), .sample_valid(sample_valid),
    .sample_in(sample_in), .sample_ready(ready[1]), .sclk_out(sclk[1]), .mosi_out(mosi[1]), .cs_n_out(cs_n[1]),
    .ldac_n_out(ldac_n[1]), .busy_out(busy[1]), .frame_done_out(done[1]));
  dac_spi_sequencer #(.signed_in(1'b0)) du (.audio_clock(audio_clock), .reset(reset), .enable_in(enable_in), .sample_valid(sample_valid),
    .sample_in(sample_in), .sample_ready(ready[2]), .sclk_out(sclk[2]), .mosi_out(mosi[2]), .cs_n_out(cs_n[2]),
    .ldac_n_out(ldac_n[2]), .busy_out(busy[2]), .frame_done_out(done[2]));

  function automatic logic [15:0] model(input logic [15:0] s, input bit sgn);
    logic [15:0] u;
    u = sgn ? s + 16'h8000 : s;
    return 16'h3000 | (u >> 4);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle frame monitor for instance k, sampled mid-cycle
  task automatic mon(input int k);
    int d = (k == 1) ? 1 : 4;
    logic [15:0] e;
    hs[k] = sample_valid && ready[k] && !reset;
    if (reset) begin
      q[k].delete();
      act[k] = 0; tmg[k] = 0; wl[k] = 0;
    end else begin
      if (hs[k]) q[k].push_back(model(sample_in, k != 2));
      if (tmg[k]) sf[k]++;
      if (pc[k] && !cs_n[k]) begin
        act[k] = 1; lc[k] = 0; run[k] = 0; nb[k] = 0; wd[k] = 0; sf[k] = 0; tmg[k] = 1;
        if (k == 0) ft.push_back(cyc);
      end
      if (act[k] && !cs_n[k]) begin
        lc[k]++;
        if (sclk[k] == ps[k]) run[k]++;
        else begin
          chk("sclk_phase", run[k], d);
          run[k] = 1;
          if (sclk[k]) begin wd[k] = {wd[k][14:0], mosi[k]}; nb[k]++; end
        end
        if (sclk[k] || run[k] != 1) chk("mosi_stable", mosi[k], pm[k]);
      end
      if (act[k] && !pc[k] && cs_n[k]) begin
        chk("bits", nb[k], 16);
        chk("cs_low", lc[k], 32 * d);
        chk("last_high", run[k], d);
        chk("sclk_idle", sclk[k], 0);
        chk("mosi_idle", mosi[k], 0);
        e = q[k].size() > 0 ? q[k].pop_front() : 16'hxxxx;
        chk("word", wd[k], e);
        lw[k] = wd[k]; act[k] = 0; wl[k] = 1; fr[k]++;
      end
      if (pl[k] && !ldac_n[k]) begin chk("ldac_expected", wl[k], 1); lac[k] = 0; end
      if (!ldac_n[k]) lac[k]++;
      if (!pl[k] && ldac_n[k] && wl[k]) begin chk("ldac_len", lac[k], d); wl[k] = 0; end
      if (done[k]) begin chk("done_expected", tmg[k], 1); chk("frame_len", sf[k], 34 * d); tmg[k] = 0; end
    end
    pc[k] = cs_n[k]; ps[k] = sclk[k]; pl[k] = ldac_n[k]; pm[k] = mosi[k];
  endtask

  task automatic tick();
    @(negedge audio_clock);
    for (int k = 0; k < 3; k++) mon(k);
    cyc++;
    @(posedge audio_clock);
    #1;
  endtask

  task automatic send(input logic [15:0] s);
    int n = 0;
    sample_in = s; sample_valid = 1;
    do begin tick(); n++; end while (!hs[0] && n < 1000);
    sample_valid = 0;
    chk("send_accept", hs[0], 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin tick(); n++; end while (!(busy == 3'b000 && ready == 3'b111 && cs_n == 3'b111) && n < 3000);
    tick();
    chk("idle_reached", busy, 0);
    for (int k = 0; k < 3; k++) chk("queue_empty", q[k].size(), 0);
  endtask

  initial begin
    logic [15:0] cin [4], cexp [4], samp [4], a, b;
    int cidx [4], n, i, f0;
    for (int k = 0; k < 3; k++) begin
      pc[k] = 1; ps[k] = 0; pl[k] = 1; pm[k] = 0; fr[k] = 0; lw[k] = 0;
    end
    reset = 1; enable_in = 1; sample_valid = 0; sample_in = 0;
    repeat (3) tick();
    chk("rst_ready", ready, 0);
    chk("rst_cs", cs_n, 3'b111);
    chk("rst_ldac", ldac_n, 3'b111);
    chk("rst_sclk", sclk, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 0;
    tick();
    chk("ready_after_rst", ready, 3'b111);
    // single sample: handshake at E0, frame starts at E1
    sample_in = 16'h1234; sample_valid = 1;
    tick();
    chk("hs_e0", hs[0], 1);
    sample_valid = 0;
    chk("ready_low_e0", ready, 0);
    chk("cs_before_e1", cs_n, 3'b111);
    tick();
    chk("cs_fall_e1", cs_n, 3'b000);
    chk("ready_high_e1", ready, 3'b111);
    chk("mosi_b15", mosi[0], 0);
    wait_idle();
    chk("word_1234", lw[0], 16'h3923);
    chk("word_1234_unsigned", lw[2], 16'h3123);
    chk("frames_1", fr[0], 1);
    // conversion corners
    cin = '{16'h8000, 16'h7FF0, 16'h0000, 16'hABCD};
    cexp = '{16'h3000, 16'h3FFF, 16'h3800, 16'h3ABC};
    cidx = '{0, 0, 0, 2};
    for (int j = 0; j < 4; j++) begin
      send(cin[j]);
      wait_idle();
      chk("conv", lw[cidx[j]], cexp[j]);
    end
    chk("conv_abcd_signed", lw[0], 16'h32BC);
    // streaming with valid held high
    ft.delete(); f0 = fr[0];
    for (int j = 0; j < 4; j++) samp[j] = 16'($urandom);
    i = 0; n = 0; sample_in = samp[0]; sample_valid = 1;
    while (i < 4 && n < 2000) begin
      tick(); n++;
      if (hs[0]) begin i++; if (i < 4) sample_in = samp[i]; end
    end
    sample_valid = 0;
    chk("stream_sent", i, 4);
    wait_idle();
    chk("stream_frames", fr[0] - f0, 4);
    chk("stream_starts", ft.size(), 4);
    for (int j = 1; j < ft.size(); j++) chk("stream_period", ft[j] - ft[j-1], 137);
    // enable low: one sample buffered, nothing starts
    enable_in = 0; a = 16'($urandom); b = 16'($urandom);
    send(a);
    chk("en_ready_low", ready, 0);
    sample_in = b; sample_valid = 1;
    repeat (20) begin tick(); chk("en_no_hs", hs[0], 0); end
    chk("en_idle_cs", cs_n, 3'b111);
    chk("en_idle_busy", busy, 0);
    sample_valid = 0; enable_in = 1;
    tick();
    chk("en_start", cs_n, 3'b000);
    wait_idle();
    chk("en_word", lw[0], model(a, 1'b1));
    // reset during bit 7 with a second sample buffered
    f0 = fr[0];
    send(16'($urandom));
    send(16'($urandom));
    repeat (65) tick();
    chk("mid_frame_cs", cs_n[0], 0);
    chk("mid_frame_bits", nb[0], 8);
    reset = 1;
    tick();
    chk("abort_cs", cs_n, 3'b111);
    chk("abort_sclk", sclk, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ldac", ldac_n, 3'b111);
    chk("abort_ready", ready, 0);
    reset = 0;
    repeat (200) begin tick(); chk("no_frame_after_abort", cs_n, 3'b111); end
    chk("abort_frames", fr[0], f0);
    chk("abort_ready_back", ready, 3'b111);
    // fastest SCLK
    send(16'h5550);
    wait_idle();
    chk("div1_word", lw[1], 16'h3D55);
    chk("div4_word", lw[0], 16'h3D55);
    chk("unsigned_word", lw[2], 16'h3555);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
